// File: rtl/display_pkg.sv
// Glyph codes and active-low 7-segment patterns shared by the message display
// multiplexer and its glyph decoder.
package display_pkg;

    localparam logic [3:0] G_F     = 4'h0;
    localparam logic [3:0] G_R     = 4'h1;
    localparam logic [3:0] G_E     = 4'h2;
    localparam logic [3:0] G_P     = 4'h3;
    localparam logic [3:0] G_A     = 4'h4;
    localparam logic [3:0] G_O     = 4'h5;
    localparam logic [3:0] G_U     = 4'h6;
    localparam logic [3:0] G_L     = 4'h7;
    localparam logic [3:0] G_DASH  = 4'h8;
    localparam logic [3:0] G_BLANK = 4'hF;

    // Segment order {a,b,c,d,e,f,g}, 0 = lit.
    localparam logic [6:0] SEG_F    = 7'b0111000;
    localparam logic [6:0] SEG_R    = 7'b1111010;
    localparam logic [6:0] SEG_E    = 7'b0110000;
    localparam logic [6:0] SEG_P    = 7'b0011000;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_O    = 7'b0000001;
    localparam logic [6:0] SEG_U    = 7'b1000001;
    localparam logic [6:0] SEG_L    = 7'b1110001;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned width_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/decodificador_glifo.sv
// Combinational glyph decoder: 4-bit message code to active-low segments.
module decodificador_glifo
    import display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            G_F:     seg_o = SEG_F;
            G_R:     seg_o = SEG_R;
            G_E:     seg_o = SEG_E;
            G_P:     seg_o = SEG_P;
            G_A:     seg_o = SEG_A;
            G_O:     seg_o = SEG_O;
            G_U:     seg_o = SEG_U;
            G_L:     seg_o = SEG_L;
            G_DASH:  seg_o = SEG_DASH;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_mux_mensagem.sv
// N-digit multiplexed 7-segment message display with decimal points, blink and
// a valid/ready load port whose messages only take effect at frame boundaries.
module display_mux_mensagem
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    input  logic [4*N_DIGITS-1:0] msg_data,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic                  blink_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   digit_en
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = width_min1(N_DIGITS);
    localparam int FRM_W = width_min1(BLINK_FRAMES);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic                  phase_on_q, phase_on_d;
    logic                  pend_full_q, pend_full_d;
    logic [4*N_DIGITS-1:0] pend_msg_q, pend_msg_d, act_msg_q, act_msg_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   digit_en_q, digit_en_d;

    logic       scan_tick, frame_end, accept, blank;
    logic [3:0] cur_code;
    logic       cur_dp;
    logic [6:0] glyph_seg;

    assign scan_tick = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign frame_end = scan_tick && (idx_q == IDX_W'(N_DIGITS - 1));
    assign accept    = msg_valid && !pend_full_q;
    assign blank     = blink_en && !phase_on_q;

    always_comb begin
        cur_code = G_BLANK;
        cur_dp   = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code = act_msg_q[4*i +: 4];
                cur_dp   = act_dp_q[i];
            end
        end
    end

    decodificador_glifo u_glifo (
        .code_i (cur_code),
        .seg_o  (glyph_seg)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d       = scan_tick ? '0 : cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        frm_d       = frm_q;
        phase_on_d  = phase_on_q;
        pend_full_d = pend_full_q;
        pend_msg_d  = pend_msg_q;
        pend_dp_d   = pend_dp_q;
        act_msg_d   = act_msg_q;
        act_dp_d    = act_dp_q;

        if (scan_tick) begin
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
        end

        if (frame_end) begin
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_d      = '0;
                phase_on_d = !phase_on_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end

        // Transfer and acceptance are exclusive: acceptance needs an empty
        // pending register, so a message taken at frame_end waits a full frame.
        if (frame_end && pend_full_q) begin
            act_msg_d   = pend_msg_q;
            act_dp_d    = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_msg_d  = msg_data;
            pend_dp_d   = dp_mask;
            pend_full_d = 1'b1;
        end

        seg_d      = blank ? SEG_OFF : glyph_seg;
        dp_d       = blank || !cur_dp;
        digit_en_d = ~(N_DIGITS'(1) << idx_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            frm_q       <= '0;
            phase_on_q  <= 1'b1;
            pend_full_q <= 1'b0;
            pend_msg_q  <= '1;
            pend_dp_q   <= '0;
            act_msg_q   <= '1;
            act_dp_q    <= '0;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            digit_en_q  <= '1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            frm_q       <= frm_d;
            phase_on_q  <= phase_on_d;
            pend_full_q <= pend_full_d;
            pend_msg_q  <= pend_msg_d;
            pend_dp_q   <= pend_dp_d;
            act_msg_q   <= act_msg_d;
            act_dp_q    <= act_dp_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            digit_en_q  <= digit_en_d;
        end
    end

    assign msg_ready = !pend_full_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_en  = digit_en_q;

endmodule

// File: tb/tb_display_mux_mensagem.sv
// Bench for display_mux_mensagem: a time-based reference model predicts every
// output from the count of clock edges since reset and the messages offered.
module tb_display_mux_mensagem;

    localparam int N     = 4;
    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = N * SD;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         msg_valid = 1'b0;
    logic         blink_en  = 1'b0;
    logic [15:0]  msg_data  = 16'h0;
    logic [3:0]   dp_mask   = 4'h0;
    logic         msg_ready;
    logic [6:0]   seg;
    logic         dp;
    logic [3:0]   digit_en;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    int           e;
    logic [15:0]  m_act, m_pend;
    logic [3:0]   m_act_dp, m_pend_dp;
    bit           m_full, m_acc;
    logic [12:0]  exp_vec;

    display_mux_mensagem #(
        .N_DIGITS     (N),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_data  (msg_data),
        .dp_mask   (dp_mask),
        .blink_en  (blink_en),
        .seg       (seg),
        .dp        (dp),
        .digit_en  (digit_en)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b0111000;
            4'd1:    return 7'b1111010;
            4'd2:    return 7'b0110000;
            4'd3:    return 7'b0011000;
            4'd4:    return 7'b0001000;
            4'd5:    return 7'b0000001;
            4'd6:    return 7'b1000001;
            4'd7:    return 7'b1110001;
            4'd8:    return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        e        = 0;
        m_act    = 16'hFFFF;
        m_act_dp = 4'h0;
        m_full   = 1'b0;
        m_acc    = 1'b0;
        exp_vec  = {7'h7F, 1'b1, 4'hF, 1'b1};
    endtask

    // One clock edge: predict what the outputs show after it, then apply loads.
    task automatic tick();
        int   idx, frame;
        bit   blank, boundary;
        logic [6:0] s;
        logic       d;
        logic [3:0] onehot;
        @(posedge clk);
        e++;
        idx      = ((e - 1) / SD) % N;
        frame    = (e - 1) / FRAME;
        blank    = blink_en && (((frame / BF) % 2) == 1);
        boundary = (e % FRAME) == 0;
        s        = blank ? 7'h7F : glyph(m_act[4*idx +: 4]);
        d        = blank ? 1'b1 : !m_act_dp[idx];
        onehot   = 4'b1 << idx;
        m_acc    = msg_valid && !m_full;
        if (boundary && m_full) begin
            m_act    = m_pend;
            m_act_dp = m_pend_dp;
            m_full   = 1'b0;
        end
        if (m_acc) begin
            m_pend    = msg_data;
            m_pend_dp = dp_mask;
            m_full    = 1'b1;
        end
        exp_vec = {s, d, ~onehot, !m_full};
        #1;
        if (m_acc) msg_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({seg, dp, digit_en, msg_ready} !== exp_vec) begin
            tests_failed++;
            $display("FAIL reset_values got=%b exp=%b", {seg, dp, digit_en, msg_ready}, exp_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            tick();
            tests_run++;
            if ({seg, dp, digit_en, msg_ready} !== exp_vec) begin
                tests_failed++;
                $display("FAIL blank_scan e=%0d got=%b exp=%b", e, {seg, dp, digit_en, msg_ready}, exp_vec);
            end
        end
    endtask

    task automatic test_load(input string name, input logic [15:0] data,
                             input logic [3:0] mask, input int offset);
        for (int i = 0; i < FRAME && (e % FRAME) != offset; i++) tick();
        msg_data  = data;
        dp_mask   = mask;
        msg_valid = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            tests_run++;
            if ({seg, dp, digit_en, msg_ready} !== exp_vec) begin
                tests_failed++;
                $display("FAIL %s e=%0d got=%b exp=%b", name, e, {seg, dp, digit_en, msg_ready}, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < FRAME && (e % FRAME) != 5; i++) tick();
        msg_data  = 16'h7640;
        dp_mask   = 4'b1000;
        msg_valid = 1'b1;
        tick();
        msg_data  = 16'h3412;
        dp_mask   = 4'b0000;
        msg_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            tests_run++;
            if ({seg, dp, digit_en, msg_ready} !== exp_vec) begin
                tests_failed++;
                $display("FAIL back_to_back e=%0d got=%b exp=%b", e, {seg, dp, digit_en, msg_ready}, exp_vec);
            end
        end
    endtask

    task automatic test_frame_end_handshake();
        for (int i = 0; i < FRAME && ((e + 1) % FRAME) != 0; i++) tick();
        msg_data  = 16'h5555;
        dp_mask   = 4'b0101;
        msg_valid = 1'b1;
        tick();
        tests_run++;
        if (msg_ready !== 1'b0 || !m_acc) begin
            tests_failed++;
            $display("FAIL frame_end_accept e=%0d got_ready=%b exp_ready=0", e, msg_ready);
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            tests_run++;
            if ({seg, dp, digit_en, msg_ready} !== exp_vec) begin
                tests_failed++;
                $display("FAIL frame_end_hs e=%0d got=%b exp=%b", e, {seg, dp, digit_en, msg_ready}, exp_vec);
            end
        end
    endtask

    task automatic test_blink();
        blink_en = 1'b1;
        for (int i = 0; i < 5 * FRAME; i++) begin
            tick();
            tests_run++;
            if ({seg, dp, digit_en, msg_ready} !== exp_vec) begin
                tests_failed++;
                $display("FAIL blink e=%0d got=%b exp=%b", e, {seg, dp, digit_en, msg_ready}, exp_vec);
            end
        end
        blink_en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!msg_valid) begin
                msg_valid = ($urandom_range(0, 5) == 0);
                msg_data  = 16'($urandom());
                dp_mask   = 4'($urandom());
            end
            if ($urandom_range(0, 40) == 0) blink_en = !blink_en;
            tick();
            tests_run++;
            if ({seg, dp, digit_en, msg_ready} !== exp_vec) begin
                tests_failed++;
                $display("FAIL random e=%0d got=%b exp=%b", e, {seg, dp, digit_en, msg_ready}, exp_vec);
            end
        end
        msg_valid = 1'b0;
        blink_en  = 1'b0;
    endtask

    task automatic test_dp_and_async_reset();
        test_load("erro_dp", 16'h2115, 4'b0010, 3);
        for (int i = 0; i < FRAME && (e % FRAME) != 9; i++) tick();
        msg_data  = 16'h8888;
        msg_valid = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        msg_valid = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({seg, dp, digit_en, msg_ready} !== exp_vec) begin
            tests_failed++;
            $display("FAIL async_reset got=%b exp=%b", {seg, dp, digit_en, msg_ready}, exp_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            tests_run++;
            if ({seg, dp, digit_en, msg_ready} !== exp_vec) begin
                tests_failed++;
                $display("FAIL post_reset e=%0d got=%b exp=%b", e, {seg, dp, digit_en, msg_ready}, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load("frere", 16'h0122, 4'b0000, 6);
        test_back_to_back();
        test_frame_end_handshake();
        test_blink();
        test_random();
        test_dp_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
